// File: rtl/adc_ramp_cal_ctrl_pkg.sv
// Shared ADC-interface definitions: calibration FSM state encoding and the
// ramp-checker result latency.
package adc_ramp_cal_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    DETECT,
    WAIT_RES,
    EVAL,
    FINAL,
    DONE
  } cal_state_e;

  // Cycles from detect_out falling until the checker verdict is valid.
  localparam int unsigned WAIT_RES_CYCLES = 3;

endpackage

// File: rtl/adc_ramp_cal_ctrl.sv
// Input-delay tap sweep: drives a detection window per tap, collects the
// ramp-checker verdict and centres the tap in the longest passing run.
module adc_ramp_cal_ctrl
  import adc_ramp_cal_ctrl_pkg::*;
#(
  parameter int unsigned TAP_WIDTH     = 5,
  parameter int unsigned DETECT_CYCLES = 1024,
  parameter int unsigned SETTLE_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cal_start,
  input  logic                 adc_is_ramp,
  output logic                 detect_out,
  output logic [TAP_WIDTH-1:0] tap_value,
  output logic                 tap_load,
  output logic                 cal_busy,
  output logic                 cal_done,
  output logic                 cal_ok
);

  localparam int unsigned MAX_CYCLES = (DETECT_CYCLES > SETTLE_CYCLES) ? DETECT_CYCLES
                                                                      : SETTLE_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);
  localparam int unsigned LEN_W = TAP_WIDTH + 1;

  localparam logic [TAP_WIDTH-1:0] LAST_TAP    = '1;
  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     DETECT_LAST = CNT_W'(DETECT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     WAIT_LAST   = CNT_W'(WAIT_RES_CYCLES - 1);

  cal_state_e           state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [TAP_WIDTH-1:0] tap_d;
  logic [TAP_WIDTH-1:0] cur_start, cur_start_d, best_start, best_start_d;
  logic [LEN_W-1:0]     cur_len, cur_len_d, best_len, best_len_d;
  logic                 detect_d, tap_load_d, busy_d, done_d, ok_d;
  logic [TAP_WIDTH-1:0] run_start;
  logic [LEN_W-1:0]     run_len;

  // Next-state, tracker and registered-output logic.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    tap_d        = tap_value;
    cur_start_d  = cur_start;
    cur_len_d    = cur_len;
    best_start_d = best_start;
    best_len_d   = best_len;
    ok_d         = cal_ok;
    run_len      = adc_is_ramp ? cur_len + LEN_W'(1) : cur_len;
    run_start    = (adc_is_ramp && cur_len == '0) ? tap_value : cur_start;

    case (state)
      IDLE: begin
        if (cal_start) begin
          state_d      = LOAD;
          cnt_d        = '0;
          tap_d        = '0;
          cur_start_d  = '0;
          cur_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          ok_d         = 1'b0;
        end
      end
      LOAD: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_d = DETECT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DETECT: begin
        if (cnt == DETECT_LAST) begin
          state_d = WAIT_RES;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      WAIT_RES: begin
        if (cnt == WAIT_LAST) begin
          state_d = EVAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      EVAL: begin
        cur_start_d = run_start;
        // A fail or the last tap closes the run; the first of equal runs is kept.
        if (!adc_is_ramp || tap_value == LAST_TAP) begin
          if (run_len > best_len) begin
            best_start_d = run_start;
            best_len_d   = run_len;
          end
          cur_len_d = '0;
        end else begin
          cur_len_d = run_len;
        end
        // Final tap is resolved here so it is already on tap_value during FINAL's strobe.
        if (tap_value == LAST_TAP) begin
          state_d = FINAL;
          if (best_len_d != '0) begin
            tap_d = best_start_d + TAP_WIDTH'((best_len_d - LEN_W'(1)) >> 1);
            ok_d  = 1'b1;
          end else begin
            tap_d = '0;
            ok_d  = 1'b0;
          end
        end else begin
          state_d = LOAD;
          tap_d   = tap_value + TAP_WIDTH'(1);
        end
      end
      FINAL:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    detect_d   = (state_d == DETECT);
    tap_load_d = (state_d == LOAD) || (state_d == FINAL);
    busy_d     = (state_d != IDLE) && (state_d != DONE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      tap_value  <= '0;
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
      detect_out <= 1'b0;
      tap_load   <= 1'b0;
      cal_busy   <= 1'b0;
      cal_done   <= 1'b0;
      cal_ok     <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      tap_value  <= tap_d;
      cur_start  <= cur_start_d;
      cur_len    <= cur_len_d;
      best_start <= best_start_d;
      best_len   <= best_len_d;
      detect_out <= detect_d;
      tap_load   <= tap_load_d;
      cal_busy   <= busy_d;
      cal_done   <= done_d;
      cal_ok     <= ok_d;
    end
  end

endmodule

// File: tb/tb_adc_ramp_cal_ctrl.sv
// Directed bench for adc_ramp_cal_ctrl with a behavioural falling-edge ramp
// checker driven by a per-tap pass mask.
module tb_adc_ramp_cal_ctrl;
  import adc_ramp_cal_ctrl_pkg::*;

  localparam int unsigned TB_DET = 16;
  localparam int unsigned TB_SET = 8;

  logic       clk;
  logic       rst_n;
  logic       cal_start;
  logic       adc_is_ramp;
  logic       detect_out;
  logic [4:0] tap_value;
  logic       tap_load;
  logic       cal_busy;
  logic       cal_done;
  logic       cal_ok;

  adc_ramp_cal_ctrl #(
    .TAP_WIDTH    (5),
    .DETECT_CYCLES(TB_DET),
    .SETTLE_CYCLES(TB_SET)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cal_start  (cal_start),
    .adc_is_ramp(adc_is_ramp),
    .detect_out (detect_out),
    .tap_value  (tap_value),
    .tap_load   (tap_load),
    .cal_busy   (cal_busy),
    .cal_done   (cal_done),
    .cal_ok     (cal_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Checker model: latch the verdict for the current tap on detect_out falling.
  logic [31:0] pass_mask;
  logic        det_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_is_ramp <= 1'b0;
      det_q       <= 1'b0;
    end else begin
      det_q <= detect_out;
      if (det_q && !detect_out) adc_is_ramp <= pass_mask[tap_value];
    end
  end

  // Output monitor: strobe counts and detect window shape.
  int   n_loads = 0;
  int   n_dones = 0;
  int   since_load = 0;
  int   hi_len = 0;
  logic prev_det = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_det   = 1'b0;
      hi_len     = 0;
      since_load = 0;
    end else begin
      if (detect_out && !prev_det) check("settle_low_len", since_load, TB_SET);
      if (!detect_out && prev_det) check("detect_high_len", hi_len, TB_DET);
      hi_len = detect_out ? hi_len + 1 : 0;
      if (tap_load) begin
        n_loads++;
        since_load = 0;
      end else begin
        since_load++;
      end
      if (cal_done) n_dones++;
      prev_det = detect_out;
    end
  end

  task automatic run_sweep(input logic [31:0] m, input int exp_tap, input int exp_ok,
                           input int exp_len, input bit repulse, input string tag);
    int l0, d0;
    bit got;
    pass_mask = m;
    l0 = n_loads;
    d0 = n_dones;
    @(negedge clk) cal_start = 1'b1;
    @(negedge clk) cal_start = 1'b0;
    check({tag, ".busy_start"}, int'(cal_busy), 1);
    check({tag, ".ok_cleared"}, int'(cal_ok), 0);
    check({tag, ".first_load"}, int'(tap_load), 1);
    check({tag, ".first_tap"}, int'(tap_value), 0);
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (repulse) cal_start = (i == 100 || i == 500);
      if (cal_done) begin
        got = 1'b1;
        break;
      end
    end
    cal_start = 1'b0;
    check({tag, ".done_seen"}, int'(got), 1);
    check({tag, ".tap"}, int'(tap_value), exp_tap);
    check({tag, ".ok"}, int'(cal_ok), exp_ok);
    check({tag, ".busy_done"}, int'(cal_busy), 0);
    check({tag, ".best_len"}, int'(dut.best_len), exp_len);
    repeat (100) @(negedge clk);
    check({tag, ".loads"}, n_loads - l0, 33);
    check({tag, ".dones"}, n_dones - d0, 1);
    check({tag, ".tap_hold"}, int'(tap_value), exp_tap);
    check({tag, ".ok_hold"}, int'(cal_ok), exp_ok);
    check({tag, ".busy_idle"}, int'(cal_busy), 0);
  endtask

  typedef struct {
    logic [31:0] mask;
    int          exp_tap;
    int          exp_ok;
    int          exp_len;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int  l0;
    bit  found;
    vecs[0] = '{rng(10, 20), 15, 1, 11};
    vecs[1] = '{32'h0, 0, 0, 0};
    vecs[2] = '{rng(3, 5) | rng(20, 27), 23, 1, 8};
    vecs[3] = '{rng(2, 4) | rng(8, 10), 3, 1, 3};
    vecs[4] = '{32'hFFFF_FFFF, 15, 1, 32};
    vecs[5] = '{rng(31, 31), 31, 1, 1};
    vecs[6] = '{rng(0, 1) | rng(30, 31), 0, 1, 2};
    vecs[7] = '{rng(0, 15) | rng(17, 31), 7, 1, 16};

    rst_n     = 1'b0;
    cal_start = 1'b0;
    pass_mask = '0;
    repeat (3) @(negedge clk);
    check("rst.detect", int'(detect_out), 0);
    check("rst.tap", int'(tap_value), 0);
    check("rst.load", int'(tap_load), 0);
    check("rst.busy", int'(cal_busy), 0);
    check("rst.done", int'(cal_done), 0);
    check("rst.ok", int'(cal_ok), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst.busy", int'(cal_busy), 0);
    check("post_rst.loads", n_loads, 0);

    foreach (vecs[k])
      run_sweep(vecs[k].mask, vecs[k].exp_tap, vecs[k].exp_ok, vecs[k].exp_len, 1'b0,
                $sformatf("vec%0d", k));

    run_sweep(rng(10, 20), 15, 1, 11, 1'b1, "repulse");

    // Reset mid-sweep while the detect window is open at tap 7.
    pass_mask = rng(3, 5) | rng(20, 27);
    @(negedge clk) cal_start = 1'b1;
    @(negedge clk) cal_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tap_value == 5'd7 && detect_out) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst.reach_tap7", int'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.detect", int'(detect_out), 0);
    check("midrst.tap", int'(tap_value), 0);
    check("midrst.load", int'(tap_load), 0);
    check("midrst.busy", int'(cal_busy), 0);
    check("midrst.done", int'(cal_done), 0);
    check("midrst.ok", int'(cal_ok), 0);
    check("midrst.state", int'(dut.state), int'(IDLE));
    check("midrst.best_len", int'(dut.best_len), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    l0 = n_loads;
    repeat (50) @(negedge clk);
    check("midrst.idle_busy", int'(cal_busy), 0);
    check("midrst.idle_loads", n_loads - l0, 0);
    check("midrst.idle_detect", int'(detect_out), 0);
    run_sweep(rng(3, 5) | rng(20, 27), 23, 1, 8, 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
